// File: rtl/timing_loop_ctrl.sv
// Gardner timing loop: PI loop filter with acquisition/tracking gear shift, NCO sample strobes, lock FSM.
// Latency: an error update on clock n moves nco_step from clock n+1; strobes and mu are registered off the NCO carry.
// Flow control: none; ted_out_en is a one-cycle qualifier, and when enable is low the block is held in IDLE.
module timing_loop_ctrl #(
    parameter int               PHASE_W      = 16,
    parameter logic [PHASE_W-1:0] W_NOM      = 16'h8000,
    parameter int               ER_SHIFT     = 8,
    parameter int               KP_SHIFT_ACQ = 1,
    parameter int               KI_SHIFT_ACQ = 4,
    parameter int               KP_SHIFT_TRK = 3,
    parameter int               KI_SHIFT_TRK = 6,
    parameter int               V_LIM        = 4096,
    parameter int               LOCK_THR     = 64,
    parameter int               LOCK_CNT     = 16,
    parameter int               UNLOCK_CNT   = 8,
    parameter int               MU_W         = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic signed [31:0]  er,
    input  logic                ted_out_en,
    output logic                strobe_sym,
    output logic                strobe_mid,
    output logic [MU_W-1:0]     mu,
    output logic [PHASE_W-1:0]  nco_step,
    output logic                locked,
    output logic [1:0]          state
);

    // Working widths: IW holds integ/v (|x| <= V_LIM <= 32767), AW has headroom for the sums.
    localparam int IW = 17;
    localparam int AW = 20;
    localparam int SW = PHASE_W + 3;
    localparam int CW = 8;

    localparam logic signed [AW-1:0] VMAX = AW'(V_LIM);
    localparam logic signed [AW-1:0] VMIN = -AW'(V_LIM);
    localparam logic signed [SW-1:0] WMAX = SW'((1 << PHASE_W) - 1);
    localparam logic signed [SW-1:0] WMIN = SW'(1);

    typedef enum logic [1:0] {IDLE = 2'b00, ACQ = 2'b01, TRK = 2'b10} st_t;

    st_t                    st;
    logic [PHASE_W-1:0]     acc;
    logic signed [IW-1:0]   integ;
    logic signed [IW-1:0]   v;
    logic                   sel;
    logic [CW-1:0]          good_cnt;
    logic [CW-1:0]          bad_cnt;

    logic signed [31:0]     er_sh;
    logic signed [15:0]     e;
    logic signed [16:0]     e_x;
    logic signed [16:0]     e_abs;
    logic                   e_good;
    int                     kp;
    int                     ki;
    logic signed [AW-1:0]   integ_sum;
    logic signed [IW-1:0]   integ_new;
    logic signed [AW-1:0]   v_sum;
    logic signed [IW-1:0]   v_new;
    logic signed [SW-1:0]   w_sum;
    logic [PHASE_W:0]       sum;

    function automatic logic signed [IW-1:0] sat_v(input logic signed [AW-1:0] x);
        if (x > VMAX)      return IW'(VMAX);
        else if (x < VMIN) return IW'(VMIN);
        else               return IW'(x);
    endfunction

    // Error conditioning, gain selection, filter arithmetic, NCO step and phase sum.
    always_comb begin
        er_sh = er >>> ER_SHIFT;
        if (er_sh > 32'sd32767)       e = 16'sh7FFF;
        else if (er_sh < -32'sd32768) e = 16'sh8000;
        else                          e = er_sh[15:0];
        e_x    = 17'(e);
        e_abs  = (e_x < 0) ? -e_x : e_x;
        e_good = (e_abs < 17'(LOCK_THR));
        kp = (st == TRK) ? KP_SHIFT_TRK : KP_SHIFT_ACQ;
        ki = (st == TRK) ? KI_SHIFT_TRK : KI_SHIFT_ACQ;
        integ_sum = AW'(integ) + AW'(e >>> ki);
        integ_new = sat_v(integ_sum);
        v_sum     = AW'(e >>> kp) + AW'(integ_new);
        v_new     = sat_v(v_sum);
        w_sum = $signed({3'b000, W_NOM}) + SW'(v);
        if (w_sum < WMIN)      nco_step = WMIN[PHASE_W-1:0];
        else if (w_sum > WMAX) nco_step = WMAX[PHASE_W-1:0];
        else                   nco_step = w_sum[PHASE_W-1:0];
        sum = {1'b0, acc} + {1'b0, nco_step};
    end

    assign state = st;

    // Lock FSM, loop filter state, NCO accumulator and strobe generation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            locked     <= 1'b0;
            acc        <= '0;
            integ      <= '0;
            v          <= '0;
            sel        <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            strobe_sym <= 1'b0;
            strobe_mid <= 1'b0;
            mu         <= '0;
        end else if (!enable) begin
            // Drop to IDLE from anywhere, even mid-symbol; mu keeps its last value.
            st         <= IDLE;
            locked     <= 1'b0;
            acc        <= '0;
            integ      <= '0;
            v          <= '0;
            sel        <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            strobe_sym <= 1'b0;
            strobe_mid <= 1'b0;
        end else if (st == IDLE) begin
            st         <= ACQ;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            strobe_sym <= 1'b0;
            strobe_mid <= 1'b0;
        end else begin
            acc        <= sum[PHASE_W-1:0];
            strobe_sym <= sum[PHASE_W] & ~sel;
            strobe_mid <= sum[PHASE_W] & sel;
            if (sum[PHASE_W]) begin
                mu  <= sum[PHASE_W-1 -: MU_W];
                sel <= ~sel;
            end
            if (ted_out_en) begin
                // Gains used here belong to the state before any transition on this edge.
                integ <= integ_new;
                v     <= v_new;
                if (st == ACQ) begin
                    if (!e_good) begin
                        good_cnt <= '0;
                    end else if (good_cnt + 1'b1 == CW'(LOCK_CNT)) begin
                        st       <= TRK;
                        locked   <= 1'b1;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end else begin
                        good_cnt <= good_cnt + 1'b1;
                    end
                end else begin
                    if (e_good) begin
                        bad_cnt <= '0;
                    end else if (bad_cnt + 1'b1 == CW'(UNLOCK_CNT)) begin
                        st       <= ACQ;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end else begin
                        bad_cnt <= bad_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timing_loop_ctrl.sv
// Bench for timing_loop_ctrl: single-update filter vectors, strobe scoreboard, lock/unlock, disable and async reset.
// Latency: expectations are expressed in cycles counted from the enable edge.
// Flow control: none; ted_out_en is pulsed by the bench.
module tb_timing_loop_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [31:0] er;
    logic               ted_out_en;
    logic               strobe_sym;
    logic               strobe_mid;
    logic [7:0]         mu;
    logic [15:0]        nco_step;
    logic               locked;
    logic [1:0]         state;

    timing_loop_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .er         (er),
        .ted_out_en (ted_out_en),
        .strobe_sym (strobe_sym),
        .strobe_mid (strobe_mid),
        .mu         (mu),
        .nco_step   (nco_step),
        .locked     (locked),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] er;
        logic [15:0]        exp_w;
    } vec_t;

    typedef struct {
        bit         sym;
        logic [7:0] mu;
        int         cyc;
    } sb_t;

    vec_t tbl[8];
    sb_t  q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   sb_on = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Every strobe seen while the scoreboard is armed must match the head of the queue.
    task automatic monitor();
        sb_t x;
        if (sb_on && (strobe_sym || strobe_mid)) begin
            if (q.size() == 0) begin
                chk("sb_extra_strobe", {strobe_sym, strobe_mid}, 0);
            end else begin
                x = q.pop_front();
                chk("sb_kind", strobe_sym, x.sym);
                chk("sb_overlap", strobe_sym & strobe_mid, 0);
                chk("sb_mu", mu, x.mu);
                chk("sb_cyc", cyc, x.cyc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic push(input bit sym, input logic [7:0] m, input int c);
        sb_t x;
        x.sym = sym;
        x.mu  = m;
        x.cyc = c;
        q.push_back(x);
    endtask

    task automatic upd(input logic signed [31:0] x);
        ted_out_en = 1'b1;
        er         = x;
        tick();
        ted_out_en = 1'b0;
        tick();
    endtask

    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    task automatic wait_sym(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (strobe_sym) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk(name, strobe_sym, 1);
    endtask

    initial begin
        int k;
        // One update from a cleared ACQ loop: W = 0x8000 + sat(e>>>1 + sat(e>>>4)).
        tbl[0] = '{32'sd4096,       16'h8009};
        tbl[1] = '{-32'sd4096,      16'h7FF7};
        tbl[2] = '{32'sd0,          16'h8000};
        tbl[3] = '{32'sd255,        16'h8000};
        tbl[4] = '{32'sd25600,      16'h8038};
        tbl[5] = '{-32'sd25600,     16'h7FC7};
        tbl[6] = '{32'sh7FFFFFFF,   16'h9000};
        tbl[7] = '{32'sh80000000,   16'h7000};

        reset = 1'b1; enable = 1'b0; ted_out_en = 1'b0; er = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sym", strobe_sym, 0);
        chk("rst_mid", strobe_mid, 0);
        chk("rst_mu", mu, 0);
        chk("rst_w", nco_step, 16'h8000);

        // Free-running at nominal step: sym/mid alternate every 2 cycles with mu=0.
        sb_on = 1'b1;
        enable = 1'b1;
        k = cyc;
        push(1, 8'd0, k + 3); push(0, 8'd0, k + 5);
        push(1, 8'd0, k + 7); push(0, 8'd0, k + 9);
        tick();
        chk("t1_acq", state, 1);
        repeat (9) tick();
        chk("t1_w", nco_step, 16'h8000);
        chk("t1_drained", q.size(), 0);
        sb_on = 1'b0;

        // A single update to W=0x8009: acc after strobe j is 9+18j, so mu first reaches 1 at j=14.
        enable = 1'b0;
        tick();
        chk("t2_idle", state, 0);
        sb_on = 1'b1;
        enable = 1'b1;
        k = cyc;
        for (int j = 0; j < 15; j++) push(j % 2 == 0, 8'((9 + 18 * j) >> 8), k + 3 + 2 * j);
        tick();
        ted_out_en = 1'b1; er = 32'sd4096;
        tick();
        ted_out_en = 1'b0;
        chk("t2_w", nco_step, 16'h8009);
        repeat (29) tick();
        chk("t2_drained", q.size(), 0);
        sb_on = 1'b0;

        for (int i = 0; i < 8; i++) begin
            restart();
            ted_out_en = 1'b1; er = tbl[i].er;
            tick();
            ted_out_en = 1'b0;
            chk($sformatf("vec%0d_w", i), nco_step, tbl[i].exp_w);
            chk($sformatf("vec%0d_state", i), state, 1);
        end

        // Repeated full-scale errors pin integ and v at the limit.
        restart();
        repeat (4) upd(32'sh7FFFFFFF);
        chk("t3_pos_sat", nco_step, 16'h9000);
        repeat (4) upd(32'sh80000000);
        chk("t3_neg_sat", nco_step, 16'h7000);

        // Lock after exactly 16 good errors, unlock after exactly 8 consecutive bad ones.
        restart();
        repeat (15) upd(32'sd0);
        chk("t4_pre_state", state, 1);
        chk("t4_pre_locked", locked, 0);
        upd(32'sd0);
        chk("t4_lock_state", state, 2);
        chk("t4_locked", locked, 1);
        upd(32'sd20000);
        upd(32'sd0);
        chk("t4_one_bad", state, 2);
        repeat (7) upd(32'sd20000);
        chk("t4_seven_bad", state, 2);
        upd(32'sd20000);
        chk("t4_unlock_state", state, 1);
        chk("t4_unlocked", locked, 0);

        // Disable mid-symbol while tracking, check IDLE ignores errors, then re-enable.
        repeat (16) upd(32'sd0);
        chk("t5_track", state, 2);
        wait_sym("t5_wait_sym_timeout");
        tick();
        enable = 1'b0;
        tick();
        chk("t5_idle", state, 0);
        chk("t5_locked", locked, 0);
        chk("t5_sym", strobe_sym, 0);
        chk("t5_mid", strobe_mid, 0);
        chk("t5_w", nco_step, 16'h8000);
        ted_out_en = 1'b1; er = 32'sh7FFFFFFF;
        tick();
        ted_out_en = 1'b0;
        chk("t5_idle_ignore_w", nco_step, 16'h8000);
        chk("t5_idle_stays", state, 0);
        sb_on = 1'b1;
        enable = 1'b1;
        k = cyc;
        push(1, 8'd0, k + 3); push(0, 8'd0, k + 5);
        repeat (5) tick();
        chk("t5_drained", q.size(), 0);
        sb_on = 1'b0;

        // Asynchronous reset lands between clock edges, right after a strobe.
        repeat (3) upd(32'sh7FFFFFFF);
        chk("t6_pre_w", nco_step, 16'h9000);
        wait_sym("t6_wait_sym_timeout");
        #2;
        reset = 1'b1;
        #1;
        chk("t6_sym", strobe_sym, 0);
        chk("t6_state", state, 0);
        chk("t6_w", nco_step, 16'h8000);
        chk("t6_mu", mu, 0);
        chk("t6_locked", locked, 0);
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
